// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready input and a one-cycle result strobe.
// Multiplies run on an iterative shift-add engine that stalls the input while busy.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal,
  output logic             dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_PASS  = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_MULHU = 4'b1101;
  localparam logic [3:0] OP_NOT   = 4'b1110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0]   r_c;
  logic               r_out_valid;
  logic               r_zero;
  logic               r_neg;
  logic               r_carry;
  logic               r_ovf;
  logic               r_illegal;

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;
  logic               r_mul_hi;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_last;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_illegal;
  logic               w_zero;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mul_res;

  // Handshake: an operation transfers on a rising edge where in_valid && in_ready;
  // a, b and sel are sampled only then. There is no output backpressure: the result
  // is presented for exactly the one cycle out_valid is high.
  assign w_accept   = in_valid && w_in_ready;
  assign w_is_mul   = (sel == OP_MUL) || (sel == OP_MULHU);
  assign w_sh       = b[SHW-1:0];
  assign w_sum      = {1'b0, a} + {1'b0, b};
  assign w_diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_res  = r_mul_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
  assign w_zero     = (w_res == '0) && !w_illegal;

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (sel)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry reports a borrow, i.e. a < b unsigned.
        w_res   = w_diff[WIDTH-1:0];
        w_carry = ~w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] == ~b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_NOR:   w_res = ~(a | b);
      OP_SLL:   w_res = a << w_sh;
      OP_SRL:   w_res = a >> w_sh;
      OP_SRA:   w_res = $signed(a) >>> w_sh;
      OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASS:  w_res = a;
      OP_NOT:   w_res = ~a;
      OP_MUL,
      OP_MULHU: w_res = '0;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid && w_is_mul) begin
          w_next_state = S_MUL;
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c         <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_mul_hi    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && !w_is_mul) begin
        r_c         <= w_res;
        r_zero      <= w_zero;
        r_neg       <= w_res[WIDTH-1];
        r_carry     <= w_carry;
        r_ovf       <= w_ovf;
        r_illegal   <= w_illegal;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_mul_hi <= (sel == OP_MULHU);
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        if (w_mul_last) begin
          // The last partial product is folded in here, so the result uses w_acc_next.
          r_cnt       <= '0;
          r_c         <= w_mul_res;
          r_zero      <= (w_mul_res == '0);
          r_neg       <= w_mul_res[WIDTH-1];
          r_carry     <= 1'b0;
          r_ovf       <= 1'b0;
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + SHW'(1);
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign c         = r_c;
  assign out_valid = r_out_valid;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: reset, single-cycle sweep, arithmetic edges,
// multiply latency/stall, reset during multiply and the illegal opcode.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sel;
  logic [W-1:0] c;
  logic         out_valid;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;
  logic         illegal;
  logic         dbg_state;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]   sw_sel [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE};
  logic [W-1:0] sw_c   [13] = '{32'h5, 32'hFFFF_FFFD, 32'h0, 32'h5, 32'h5,
                                32'hFFFF_FFFA, 32'h10, 32'h0, 32'h0, 32'h1,
                                32'h1, 32'h1, 32'hFFFF_FFFE};
  logic [12:0]  sw_cy = 13'b0_0000_0000_0010;

  // Clock / reset
  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .c         (c),
    .out_valid (out_valid),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // Scoreboard checks
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic ez, input logic en,
                           input logic ec, input logic eo);
    chk1({tag, "_zero"},  zero,  ez);
    chk1({tag, "_neg"},   neg,   en);
    chk1({tag, "_carry"}, carry, ec);
    chk1({tag, "_ovf"},   ovf,   eo);
  endtask

  // Driver: present one operation, let it be accepted, return 1 time unit after the edge
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] ts);
    a        = ta;
    b        = tb;
    sel      = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [3:0] ts, input logic [W-1:0] exp);
    int   busy;
    int   cyc;
    logic seen;
    drive(ta, tb, ts);
    in_valid = 1'b0;
    chk1({tag, "_acc_ov"},    out_valid, 1'b0);
    chk1({tag, "_acc_rdy"},   in_ready,  1'b0);
    chk1({tag, "_acc_state"}, dbg_state, 1'b1);
    busy = (in_ready == 1'b0) ? 1 : 0;
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (k < W - 2) begin
        a        = $urandom;
        b        = $urandom;
        sel      = 4'($urandom_range(0, 15));
        in_valid = k[0];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) seen = 1'b1;
      else if (!in_ready) busy++;
    end
    chk1({tag, "_done"},    seen, 1'b1);
    chk({tag, "_latency"},  32'(cyc),  32'(W));
    chk({tag, "_busy"},     32'(busy), 32'(W));
    chk({tag, "_c"},        c, exp);
    chk_flags(tag, (exp == '0), exp[W-1], 1'b0, 1'b0);
    chk1({tag, "_rdy_back"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk1({tag, "_ov_drop"}, out_valid, 1'b0);
    chk({tag, "_c_hold"},   c, exp);
  endtask

  initial begin
    int nov;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sel      = '0;
    #12;
    chk("rst_c", c, '0);
    chk1("rst_ov", out_valid, 1'b0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("rst_ill", illegal, 1'b0);
    chk1("rst_rdy", in_ready, 1'b1);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk1("idle_ov", out_valid, 1'b0);
      chk1("idle_rdy", in_ready, 1'b1);
    end

    // Back-to-back single-cycle sweep, a=1 b=4
    for (int i = 0; i < 13; i++) begin
      drive(32'd1, 32'd4, sw_sel[i]);
      chk($sformatf("sweep%0d_c", i), c, sw_c[i]);
      chk1($sformatf("sweep%0d_ov", i), out_valid, 1'b1);
      chk_flags($sformatf("sweep%0d", i), (sw_c[i] == '0), sw_c[i][W-1], sw_cy[i], 1'b0);
    end

    drive(32'h7FFF_FFFF, 32'h1, 4'h0);
    chk("add_ovf_c", c, 32'h8000_0000);
    chk_flags("add_ovf", 1'b0, 1'b1, 1'b0, 1'b1);
    drive(32'hFFFF_FFFF, 32'h1, 4'h0);
    chk("add_cy_c", c, 32'h0);
    chk_flags("add_cy", 1'b1, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with no clock edge in between
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_c", c, '0);
    chk1("arst_ov", out_valid, 1'b0);
    chk_flags("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("arst_rdy", in_ready, 1'b1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("arst_noacc_ov", out_valid, 1'b0);

    drive(32'h8000_0000, 32'h1, 4'h1);
    chk("sub_ovf_c", c, 32'h7FFF_FFFF);
    chk_flags("sub_ovf", 1'b0, 1'b0, 1'b0, 1'b1);
    drive(32'h8000_0000, 32'd31, 4'h8);
    chk("sra_c", c, 32'hFFFF_FFFF);
    drive(32'h1, 32'hFFFF_FFFF, 4'hA);
    chk("sltu_c", c, 32'h1);
    drive(32'h1, 32'hFFFF_FFFF, 4'h9);
    chk("slt_c", c, 32'h0);
    chk1("slt_zero", zero, 1'b1);
    in_valid = 1'b0;

    run_mul("mul_ff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hC, 32'h1);
    run_mul("mulhu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hD, 32'hFFFF_FFFE);
    run_mul("mul_7x6",  32'd7,         32'd6,         4'hC, 32'd42);
    run_mul("mulhu_16", 32'h0001_0000, 32'h0001_0000, 4'hD, 32'h1);

    // Reset in the middle of a multiply
    drive(32'hFFFF_FFFF, 32'h3, 4'hC);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk1("mrst_rdy", in_ready, 1'b1);
    chk1("mrst_ov", out_valid, 1'b0);
    chk1("mrst_state", dbg_state, 1'b0);
    chk("mrst_c", c, '0);
    #1 rst = 1'b0;
    nov = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) nov++;
    end
    chk("mrst_no_result", 32'(nov), 32'd0);

    drive(32'd2, 32'd3, 4'h0);
    chk("post_add_c", c, 32'd5);
    chk1("post_add_ov", out_valid, 1'b1);
    chk1("post_add_ill", illegal, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("post_add_ov_drop", out_valid, 1'b0);
    chk("post_add_c_hold", c, 32'd5);

    drive(32'h1234_5678, 32'h9ABC_DEF0, 4'hF);
    chk("ill_c", c, 32'h0);
    chk1("ill_flag", illegal, 1'b1);
    chk1("ill_ov", out_valid, 1'b1);
    chk_flags("ill", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(32'd1, 32'd1, 4'h0);
    chk("after_ill_c", c, 32'd2);
    chk1("after_ill_flag", illegal, 1'b0);
    in_valid = 1'b0;

    // Report
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU (a, b, sel -> c).
- Adds WIDTH generalisation, a valid/ready input handshake, a registered result with a one-cycle out_valid strobe, and status flags.
- Adds an iterative shift-add multiplier that stalls the input while it runs.
- Sits between the operand/decode logic and the writeback register.

Parameters:
- WIDTH, 32, operand/result width; legal ≥ 4, power of two. Shift amount is b[log2(WIDTH)-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operands and sel valid this cycle
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sel  in  4  opcode
- c  out  WIDTH  registered result
- out_valid  out  1  one-cycle strobe; c and flags are new this cycle
- zero  out  1  c == 0
- neg  out  1  c[WIDTH-1]
- carry  out  1  ADD carry-out, or SUB borrow (a < b unsigned); 0 for all other ops
- ovf  out  1  signed overflow for ADD/SUB; 0 for all other ops
- illegal  out  1  opcode 1111 accepted

Behaviour:
- Reset (async, immediate): c=0, out_valid=0, zero=0, neg=0, carry=0, ovf=0, illegal=0, in_ready=1, FSM=IDLE, mul counter=0.
- Reset mid-multiply: aborts the operation; no out_valid is produced for it.
- Opcodes:
  - 0000 ADD; 0001 SUB (a-b)
  - 0010 AND; 0011 OR; 0100 XOR; 0101 NOR
  - 0110 SLL a by sh; 0111 SRL; 1000 SRA
  - 1001 SLT signed (result 1 or 0); 1010 SLTU unsigned
  - 1011 PASS a; 1110 NOT a
  - 1100 MUL low WIDTH bits of a*b; 1101 MULHU high WIDTH bits of unsigned a*b
  - 1111 illegal: c=0, illegal=1, other flags 0.
- Arithmetic: ADD/SUB are computed at WIDTH+1 bits.
  - carry is bit WIDTH of a+b for ADD; for SUB it is the inverted bit WIDTH of a+~b+1.
  - ovf = (sign a == sign of operand actually added) && (sign result != sign a).
- FSM states:
  - IDLE: in_ready=1.
  - MUL: in_ready=0.
- Single-cycle ops (all except 1100/1101):
  - Accepted at edge k; c, flags and out_valid=1 are registered at edge k.
  - Results are visible in the cycle after the accept edge (latency 1).
  - Back-to-back accepts give throughput 1 per cycle.
- Multiply ops:
  - Accepted at edge k: latch a and b, clear the 2*WIDTH accumulator, enter MUL, count=0, out_valid=0.
  - Each MUL edge: if multiplier LSB is set, add the shifted multiplicand; shift; count++.
  - At the edge where count reaches WIDTH-1 (the WIDTH-th MUL edge): register c (low or high half), flags (zero, neg; carry=ovf=0), out_valid=1, and return to IDLE.
  - Total: result visible WIDTH cycles after the accept edge; in_ready is low for those WIDTH cycles.
- out_valid is high for exactly one cycle per accepted op; it is 0 on every edge with no completion.
- c and flags hold their last value until the next completion.
- in_valid while in_ready=0 is ignored: no transfer, operands not sampled. The producer must hold.
- sel and operands are sampled only at the accept edge. Changes during MUL have no effect.
- No output backpressure: the consumer must take the result in the out_valid cycle.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 and in_ready=1 immediately; release -> no out_valid until first accept.
- Single-cycle sweep, WIDTH=32, a=1, b=4, sel stepped each cycle with in_valid=1:
  - ADD c=5; SUB c=0xFFFFFFFD, carry=1, neg=1
  - AND c=0, zero=1; OR c=5; XOR c=5; NOR c=0xFFFFFFFA
  - SLL c=16; SRL c=0; SLT c=1; PASS c=1; NOT c=0xFFFFFFFE
  - out_valid high every cycle.
- Overflow/carry: ADD 0x7FFFFFFF+1 -> c=0x80000000, ovf=1, carry=0. ADD 0xFFFFFFFF+1 -> c=0, zero=1, carry=1, ovf=0.
- SRA 0x80000000 by b=31 -> c=0xFFFFFFFF. SLTU a=1, b=0xFFFFFFFF -> c=1. SLT with the same operands -> c=0.
- Multiply: MUL 0xFFFFFFFF*0xFFFFFFFF -> c=1 after 32 cycles, in_ready low exactly 32 cycles. MULHU with the same operands -> c=0xFFFFFFFE. Operand change and in_valid pulses during busy are ignored.
- Reset mid-MUL at cycle 10 -> no out_valid, in_ready=1. Next ADD 2+3 -> c=5 one cycle later. Opcode 1111 -> c=0, illegal=1 for that result only.
